// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D cache to physical memory arbiter.
// Contents: arb_state_t (arbiter FSM states), grant_t (last-served requester),
// ADDR_W / LINE_W default widths.
package cache_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single physical memory port between the I-cache (read-only) and
// the D-cache (read/write). One line transaction at a time; the grant is held
// until pmem_resp, which is forwarded combinationally to the owning cache.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_read, i_address             I-cache line read request
//   i_resp, i_rdata               I-cache completion pulse / line data
//   d_read, d_write, d_address,
//   d_wdata                       D-cache line read / writeback request
//   d_resp, d_rdata               D-cache completion pulse / line data
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata      physical memory request
//   pmem_resp, pmem_rdata         physical memory completion / read data
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the grant on
// simultaneous requests; otherwise the D-cache always wins a collision.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned LINE_WIDTH = LINE_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    arb_state_t state_q, state_d;
    arb_state_t collide_state;
    logic       i_req;
    logic       d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Read data is a plain broadcast; only the resp pulses carry ownership.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant_q, last_grant_d;

    // On a collision, favour whichever requester was not served last.
    assign collide_state = (last_grant_q == GRANT_D) ? SERVE_I : SERVE_D;

    // Remember the owner of every completed transaction.
    always_comb begin
        last_grant_d = last_grant_q;
        if (pmem_resp && (state_q == SERVE_I)) begin
            last_grant_d = GRANT_I;
        end else if (pmem_resp && (state_q == SERVE_D)) begin
            last_grant_d = GRANT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign collide_state = SERVE_D;
`endif

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory-port / response decode.
    always_comb begin
        state_d      = state_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                // pmem_resp is ignored here; strobes start next cycle.
                if (i_req && d_req) begin
                    state_d = collide_state;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                // A writeback takes precedence if both strobes are raised.
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A granted requester must hold its request until its resp.
    a_i_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE_I) |-> i_read);
    a_d_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE_D) |-> (d_read | d_write));

endmodule
